// File: rtl/mem_responder.sv
// mem_responder: fixed-latency 16-bit word memory responder with byte-masked writes and a sticky protocol error flag
module mem_responder #(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        busy,
  output logic        proto_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic op_wr;
  logic [ADDR_BITS-1:0] addr, rd_addr;
  logic [15:0] wdata;
  logic [1:0] be;
  logic [15:0] mem [2**ADDR_BITS];
  logic req, rd_op, unused;
  assign req = mem_read | mem_write;
  assign unused = ^{mem_address[0], mem_address[15:ADDR_BITS+1]};
  assign mem_resp = state == RESP;
  assign busy = state != IDLE;
  // With LATENCY=1 the request is still being latched on the edge that enters RESP
  assign rd_addr = state == IDLE ? mem_address[ADDR_BITS:1] : addr;
  assign rd_op = state == IDLE ? ~mem_write : ~op_wr;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = (LATENCY > 1) ? WAIT : RESP;
      WAIT: if (cnt == 4'd1) state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      be        <= '0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        cnt   <= 4'(LATENCY - 1);
        op_wr <= mem_write;
        addr  <= mem_address[ADDR_BITS:1];
        wdata <= mem_wdata;
        be    <= mem_byte_enable;
        if (mem_read && mem_write) proto_err <= 1'b1;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state_nx == RESP && state != RESP && rd_op) mem_rdata <= mem[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (state == RESP && op_wr) begin
      if (be[0]) mem[addr][7:0] <= wdata[7:0];
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
    end
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from request-sampling edge to mem_resp cycle; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 8: word-address width, giving a backing store of 2^ADDR_BITS 16-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mem_read, input, 1 bit: read request from the initiator.
REQ-006 SHALL have port mem_write, input, 1 bit: write request from the initiator.
REQ-007 SHALL have port mem_byte_enable, input, 2 bits (lc3b_mem_wmask): bit0 enables the low byte, bit1 the high byte.
REQ-008 SHALL have port mem_address, input, 16 bits (lc3b_word): byte address; bit0 ignored, bits [ADDR_BITS:1] select the word, higher bits ignored (address aliasing).
REQ-009 SHALL have port mem_wdata, input, 16 bits (lc3b_word): write data.
REQ-010 SHALL have port mem_resp, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port mem_rdata, output, 16 bits (lc3b_word): read data, valid while mem_resp=1.
REQ-012 SHALL have port busy, output, 1 bit: high while a request is latched and not yet completed.
REQ-013 SHALL have port proto_err, output, 1 bit: sticky flag for a protocol violation.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: at a rising edge with mem_read|mem_write=1, SHALL latch op, word address, mem_wdata and mem_byte_enable, and load the counter with LATENCY-1.
- Next state: WAIT if LATENCY>1, else RESP.
REQ-016 WAIT: SHALL decrement the counter each edge and enter RESP when the counter reaches 1.
- Net effect: mem_resp is high during the cycle LATENCY cycles after the sampling edge.
REQ-017 RESP: SHALL drive mem_resp=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-018 Reads: SHALL drive mem_rdata with the array word at the latched address during the RESP cycle.
- mem_rdata SHALL hold that value until the next RESP or reset.
REQ-019 Writes: SHALL update the array at the edge ending the RESP cycle, per latched byte enables only.
- mem_byte_enable=2'b00 SHALL complete with mem_resp and leave the array unchanged.
- mem_rdata SHALL be unchanged by a write.
REQ-020 SHALL ignore changes on request, address, data and mask inputs after the sampling edge until return to IDLE.
- A request deasserted mid-operation SHALL still complete, with mem_resp pulsed.
REQ-021 A request still asserted in the IDLE cycle after RESP SHALL be sampled as a new access (minimum 1 idle cycle between accesses).
REQ-022 If mem_read and mem_write are both 1 at a sampling edge, SHALL perform a write and set proto_err.
REQ-023 proto_err SHALL stay set until reset.
REQ-024 busy SHALL be 1 in WAIT and RESP, 0 in IDLE.
REQ-025 A read following a write to the same word SHALL return the written data (no stale read).

Reset
REQ-026 While rst_n=0, asynchronously: state=IDLE, mem_resp=0, mem_rdata=16'h0000, busy=0, proto_err=0, counter=0.
REQ-027 Reset asserted mid-operation SHALL abort the access; a pending write SHALL NOT be committed.
REQ-028 Array contents SHALL NOT be cleared by reset; the array is uninitialised at time zero.
REQ-029 The first request SHALL be sampled at the first rising edge with rst_n=1.

Verification
REQ-030 Write 16'hBEEF to 16'h0010 with mask 2'b11, then read 16'h0010 (LATENCY=3) -> mem_resp 3 cycles after each sampling edge, one cycle wide; read returns 16'hBEEF.
REQ-031 After REQ-030, write 16'h1234 with mask 2'b01 to 16'h0011, then read 16'h0010 -> mem_rdata=16'hBE34.
REQ-032 Read sampled, mem_read dropped the next cycle, mem_address changed -> mem_resp still pulses at +3 with data from the originally latched address.
REQ-033 mem_read=mem_write=1 with wdata 16'h00AA to 16'h0020 -> proto_err=1 and stays 1; subsequent read of 16'h0020 returns 16'h00AA.
REQ-034 Write 16'h5555 to 16'h0030, then assert rst_n=0 during WAIT, release, read 16'h0030 -> mem_resp=0 during reset; read returns the prior contents, not 16'h5555.
REQ-035 LATENCY=1 with mem_read held high continuously -> mem_resp pulses every 2 cycles, busy toggles 1/0.
